// File: rtl/mc_ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl_fsm_if
//  Description : Control bundle between the multi-cycle sequencer and the
//                PC/IR/register-file/ALU datapath.
//                master  = sequencer (consumes opcode/funct/zero, drives
//                          state, enables, mux selects, illegal, instret)
//                slave   = datapath  (drives opcode/funct/zero, consumes
//                          everything else)
//  Revision    : 1.0  initial release
// ============================================================================
interface mc_ctrl_fsm_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic [2:0]       state;
    logic             pcwre;
    logic [1:0]       pcsrc;
    logic             irwre;
    logic             insmemrw;
    logic             regwre;
    logic             regdst;
    logic             alusrcb;
    logic             extsel;
    logic [2:0]       aluop;
    logic             mrd;
    logic             mwr;
    logic             dbdatasrc;
    logic             illegal;
    logic [CNT_W-1:0] instret;

    modport master (
        input  opcode, funct, zero,
        output state, pcwre, pcsrc, irwre, insmemrw, regwre, regdst,
               alusrcb, extsel, aluop, mrd, mwr, dbdatasrc, illegal, instret
    );

    modport slave (
        output opcode, funct, zero,
        input  state, pcwre, pcsrc, irwre, insmemrw, regwre, regdst,
               alusrcb, extsel, aluop, mrd, mwr, dbdatasrc, illegal, instret
    );
endinterface
`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : mc_ctrl_fsm
//  Description : Multi-cycle control sequencer (IF/ID/EXE/MEM/WB/HALT) for
//                the single-issue MIPS core. Outputs are decoded
//                combinationally from the current state and the latched
//                opcode/funct/zero; one PC-write pulse per retired
//                instruction, counted in instret.
//  Ports       : clk   - rising-edge clock
//                rst_n - asynchronous reset, active low
//                bus   - mc_ctrl_fsm_if.master (opcode/funct/zero in,
//                        state/enables/selects/illegal/instret out)
//  Revision    : 1.0  initial release
// ============================================================================
module mc_ctrl_fsm #(
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    mc_ctrl_fsm_if.master  bus
);
    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b101
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_HALT  = 6'b111111;

    localparam logic [5:0] c_FN_ADD   = 6'b100000;
    localparam logic [5:0] c_FN_SUB   = 6'b100010;
    localparam logic [5:0] c_FN_AND   = 6'b100100;
    localparam logic [5:0] c_FN_OR    = 6'b100101;
    localparam logic [5:0] c_FN_SLT   = 6'b101010;

    localparam logic [2:0] c_ALU_ADD  = 3'b000;
    localparam logic [2:0] c_ALU_SUB  = 3'b001;
    localparam logic [2:0] c_ALU_AND  = 3'b010;
    localparam logic [2:0] c_ALU_OR   = 3'b011;
    localparam logic [2:0] c_ALU_SLT  = 3'b100;

    state_t           r_state;
    logic [CNT_W-1:0] r_instret;

    logic       w_is_rtype;
    logic       w_funct_ok;
    logic [2:0] w_r_aluop;
    logic       w_legal;
    logic       w_is_mem;

    logic       w_pcwre;
    logic [1:0] w_pcsrc;
    logic       w_irwre;
    logic       w_insmemrw;
    logic       w_regwre;
    logic       w_regdst;
    logic       w_alusrcb;
    logic       w_extsel;
    logic [2:0] w_aluop;
    logic       w_mrd;
    logic       w_mwr;
    logic       w_dbdatasrc;
    logic       w_illegal;

    // Instruction classification from the latched IR fields.
    always_comb begin
        w_is_rtype = (bus.opcode == c_OP_RTYPE);
        w_is_mem   = (bus.opcode == c_OP_LW) || (bus.opcode == c_OP_SW);
        w_funct_ok = 1'b1;
        w_r_aluop  = c_ALU_ADD;
        case (bus.funct)
            c_FN_ADD: w_r_aluop = c_ALU_ADD;
            c_FN_SUB: w_r_aluop = c_ALU_SUB;
            c_FN_AND: w_r_aluop = c_ALU_AND;
            c_FN_OR:  w_r_aluop = c_ALU_OR;
            c_FN_SLT: w_r_aluop = c_ALU_SLT;
            default:  w_funct_ok = 1'b0;
        endcase
        case (bus.opcode)
            c_OP_RTYPE:                       w_legal = w_funct_ok;
            c_OP_ADDI, c_OP_LW, c_OP_SW,
            c_OP_BEQ, c_OP_J, c_OP_HALT:      w_legal = 1'b1;
            default:                          w_legal = 1'b0;
        endcase
    end

    // Per-state control decode. PC write is raised only in the last state of
    // each instruction, so it doubles as the retire strobe.
    always_comb begin
        w_pcwre     = 1'b0;
        w_pcsrc     = 2'b00;
        w_irwre     = 1'b0;
        w_insmemrw  = 1'b0;
        w_regwre    = 1'b0;
        w_regdst    = 1'b0;
        w_alusrcb   = 1'b0;
        w_extsel    = 1'b0;
        w_aluop     = c_ALU_ADD;
        w_mrd       = 1'b0;
        w_mwr       = 1'b0;
        w_dbdatasrc = 1'b0;
        w_illegal   = 1'b0;
        case (r_state)
            S_IF: begin
                w_irwre    = 1'b1;
                w_insmemrw = 1'b1;
            end
            S_ID: begin
                if (!w_legal) begin
                    // Unknown encoding retires as a NOP through PC+4.
                    w_pcwre   = 1'b1;
                    w_illegal = 1'b1;
                end else if (bus.opcode == c_OP_J) begin
                    w_pcwre = 1'b1;
                    w_pcsrc = 2'b10;
                end
            end
            S_EXE: begin
                if (bus.opcode == c_OP_BEQ) begin
                    w_aluop = c_ALU_SUB;
                    w_pcwre = 1'b1;
                    w_pcsrc = bus.zero ? 2'b01 : 2'b00;
                end else if (w_is_rtype) begin
                    w_aluop = w_r_aluop;
                end else begin
                    w_alusrcb = 1'b1;
                    w_extsel  = 1'b1;
                end
            end
            S_MEM: begin
                w_alusrcb = 1'b1;
                if (bus.opcode == c_OP_SW) begin
                    w_mwr   = 1'b1;
                    w_pcwre = 1'b1;
                end else begin
                    w_mrd = 1'b1;
                end
            end
            S_WB: begin
                w_regwre    = 1'b1;
                w_pcwre     = 1'b1;
                w_regdst    = w_is_rtype;
                w_dbdatasrc = (bus.opcode == c_OP_LW);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IF;
            r_instret <= '0;
        end else begin
            case (r_state)
                S_IF: r_state <= S_ID;
                S_ID: begin
                    if (!w_legal || bus.opcode == c_OP_J)
                        r_state <= S_IF;
                    else if (bus.opcode == c_OP_HALT)
                        r_state <= S_HALT;
                    else
                        r_state <= S_EXE;
                end
                S_EXE: begin
                    if (bus.opcode == c_OP_BEQ)
                        r_state <= S_IF;
                    else if (w_is_mem)
                        r_state <= S_MEM;
                    else
                        r_state <= S_WB;
                end
                S_MEM:   r_state <= (bus.opcode == c_OP_LW) ? S_WB : S_IF;
                S_WB:    r_state <= S_IF;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_IF;
            endcase
            if (w_pcwre)
                r_instret <= r_instret + CNT_W'(1);
        end
    end

    assign bus.state     = r_state;
    assign bus.pcwre     = w_pcwre;
    assign bus.pcsrc     = w_pcsrc;
    assign bus.irwre     = w_irwre;
    assign bus.insmemrw  = w_insmemrw;
    assign bus.regwre    = w_regwre;
    assign bus.regdst    = w_regdst;
    assign bus.alusrcb   = w_alusrcb;
    assign bus.extsel    = w_extsel;
    assign bus.aluop     = w_aluop;
    assign bus.mrd       = w_mrd;
    assign bus.mwr       = w_mwr;
    assign bus.dbdatasrc = w_dbdatasrc;
    assign bus.illegal   = w_illegal;
    assign bus.instret   = r_instret;
endmodule
`default_nettype wire

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multi-cycle control sequencer for the single-issue MIPS core. It steps the PC/instruction-memory datapath through IF/ID/EXE/MEM/WB, and issues every per-state enable and mux select that datapath consumes. It issues exactly one PC-write pulse per retired instruction and counts retired instructions. It sits beside the PC/IR/register-file/ALU datapath and receives only the latched opcode/funct and the ALU zero flag.

## Interface
- CNT_W, 16, width of retired-instruction counter
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous reset, active-low (0 = reset)
- opcode  in  6  IR[31:26], stable from ID onward
- funct  in  6  IR[5:0], used only when opcode=000000
- zero  in  1  ALU zero flag, sampled only in EXE
- state  out  3  current state: IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=101
- PCWre  out  1  PC load enable
- PCSrc  out  2  00 PC+4, 01 PC+4+(simm<<2), 10 jump target
- IRWre  out  1  IR load enable
- InsMemRW  out  1  instruction memory read
- RegWre  out  1  register file write
- RegDst  out  1  1 = rd, 0 = rt
- ALUSrcB  out  1  1 = extended immediate
- ExtSel  out  1  1 = sign-extend
- ALUOp  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt
- mRD, mWR  out  1 each  data memory read/write
- DBDataSrc  out  1  1 = memory data to write-back
- illegal  out  1  one-cycle pulse on an unknown opcode/funct
- instret  out  CNT_W  retired-instruction count

## Operation
- Supported instructions: R-type add(100000)/sub(100010)/and(100100)/or(100101)/slt(101010); addi 001000; lw 100011; sw 101011; beq 000100; j 000010; halt 111111.
- Transitions:
  - IF -> ID always.
  - From ID: j -> IF; halt -> HALT; illegal -> IF; all others -> EXE.
  - From EXE: beq -> IF; lw/sw -> MEM; R/addi -> WB.
  - From MEM: sw -> IF; lw -> WB.
  - WB -> IF.
  - HALT -> HALT until reset.
- Outputs are decoded combinationally from state, opcode, funct and zero. Any output not listed for a state is 0.
- IF: IRWre=1, InsMemRW=1.
- ID, j: PCWre=1, PCSrc=10.
- ID, illegal: PCWre=1, PCSrc=00, illegal=1. The illegal instruction executes as a NOP.
- EXE:
  - R-type: ALUSrcB=0, ALUOp per funct.
  - addi/lw/sw: ALUSrcB=1, ExtSel=1, ALUOp=000.
  - beq: ALUOp=001, PCWre=1, PCSrc = zero ? 01 : 00.
- MEM:
  - lw: mRD=1, ALUSrcB=1.
  - sw: mWR=1, ALUSrcB=1, PCWre=1, PCSrc=00.
- WB:
  - RegWre=1, PCWre=1, PCSrc=00.
  - R-type: RegDst=1, DBDataSrc=0.
  - addi: RegDst=0, DBDataSrc=0.
  - lw: RegDst=0, DBDataSrc=1.
- HALT: all outputs 0. PC frozen.
- PCWre is asserted in exactly one state per instruction, the final one. instret increments on every clock edge where PCWre=1 and wraps modulo 2^CNT_W.

## Timing
- Reset (RST=0), asynchronously and for as long as it is held: state=IF, instret=0. Outputs therefore show IF values: IRWre=1, InsMemRW=1, everything else 0.
- First edge after RST rises: IF -> ID.
- Reset asserted mid-instruction: the FSM aborts immediately to IF. No partial write completes after reset asserts.
- Cycles per instruction: j/illegal 2; beq 3; sw 4; R/addi 4; lw 5.
- PC and instret update on the edge that leaves the PCWre state.
- opcode and zero are never sampled in IF.
- zero is sampled only in EXE.
- instret wrap: the all-ones value goes to 0 on the next retire.

## Test plan
- Hold RST=0 for 3 cycles, then release: state=000, IRWre=1, PCWre=0, instret=0. state=001 after the first edge.
- opcode=000000, funct=100000: state sequence 000,001,010,100,000. PCWre=1 only in WB, with RegWre=1 and RegDst=1. instret=1.
- lw: sequence 000,001,010,011,100,000. mRD=1 in MEM only, DBDataSrc=1 in WB. instret increments once after 5 cycles.
- beq with zero=1: PCSrc=01 and PCWre=1 in EXE, back to IF after 3 cycles. With zero=0: PCSrc=00.
- j: PCWre=1, PCSrc=10 in ID, 2-cycle instruction. Opcode 010101: illegal=1 in ID, NOP retire.
- halt: state=101 held for 10 cycles, PCWre=0, instret unchanged. Pulsing RST=0 mid-MEM of an sw leaves mWR=0 and returns state to 000 immediately.
